// File: rtl/instr_loader.sv
`default_nettype none
// ============================================================================
// Module   : instr_loader
// Brief    : Assembles UART bytes MSB-first into instruction words and writes
//            them to consecutive instruction-memory addresses from 0.
// Revision : 1.0 - initial release
// ============================================================================
module instr_loader #(
  parameter int                     NB_DATA_BUS = 32,
  parameter int                     NB_BYTE     = 8,
  parameter int                     N_ADDRESS   = 128,
  parameter int                     NB_ADDRESS  = $clog2(N_ADDRESS),
  parameter logic [NB_DATA_BUS-1:0] HALT_WORD   = 32'hFFFF_FFFF
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [NB_BYTE-1:0]    i_rx_data,
  input  logic                  i_rx_valid,
  output logic                  o_w_en,
  output logic [NB_ADDRESS-1:0] o_w_addr,
  output logic [NB_DATA_BUS-1:0] o_w_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_overflow,
  output logic [NB_ADDRESS:0]   o_n_words
);

  localparam int C_BYTES_PER_WORD = NB_DATA_BUS / NB_BYTE;
  localparam int C_NB_BCNT        = (C_BYTES_PER_WORD > 1) ? $clog2(C_BYTES_PER_WORD) : 1;
  localparam int C_NB_PART        = NB_DATA_BUS - NB_BYTE;
  localparam logic [C_NB_BCNT-1:0]  C_LAST_BYTE = C_NB_BCNT'(C_BYTES_PER_WORD - 1);
  localparam logic [NB_ADDRESS-1:0] C_LAST_ADDR = NB_ADDRESS'(N_ADDRESS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                  state_q;
  logic [NB_ADDRESS-1:0]   addr_q;
  logic [C_NB_BCNT-1:0]    byte_cnt_q;
  // Only the bytes still waiting for completion are kept; the oldest byte of
  // a finished word is never needed again.
  logic [C_NB_PART-1:0]    part_q;
  logic                    w_en_q;
  logic [NB_ADDRESS-1:0]   w_addr_q;
  logic [NB_DATA_BUS-1:0]  w_data_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    overflow_q;
  logic [NB_ADDRESS:0]     n_words_q;

  logic [NB_DATA_BUS-1:0]  word_d;

  assign word_d = {part_q, i_rx_data};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      byte_cnt_q <= '0;
      part_q     <= '0;
      w_en_q     <= 1'b0;
      w_addr_q   <= '0;
      w_data_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      n_words_q  <= '0;
    end else begin
      w_en_q <= 1'b0;
      // A start pulse restarts the load from any state and drops any byte
      // arriving in the same cycle.
      if (i_start) begin
        state_q    <= ST_LOAD;
        addr_q     <= '0;
        byte_cnt_q <= '0;
        part_q     <= '0;
        busy_q     <= 1'b1;
        done_q     <= 1'b0;
        overflow_q <= 1'b0;
        n_words_q  <= '0;
      end else begin
        case (state_q)
          ST_LOAD: begin
            if (i_rx_valid) begin
              part_q <= word_d[C_NB_PART-1:0];
              if (byte_cnt_q == C_LAST_BYTE) begin
                byte_cnt_q <= '0;
                w_en_q     <= 1'b1;
                w_addr_q   <= addr_q;
                w_data_q   <= word_d;
                addr_q     <= addr_q + 1'b1;
                n_words_q  <= n_words_q + 1'b1;
                if (word_d == HALT_WORD) begin
                  state_q    <= ST_DONE;
                  busy_q     <= 1'b0;
                  done_q     <= 1'b1;
                  overflow_q <= 1'b0;
                end else if (addr_q == C_LAST_ADDR) begin
                  state_q    <= ST_DONE;
                  busy_q     <= 1'b0;
                  done_q     <= 1'b1;
                  overflow_q <= 1'b1;
                end
              end else begin
                byte_cnt_q <= byte_cnt_q + 1'b1;
              end
            end
          end
          ST_IDLE, ST_DONE: begin
            state_q <= state_q;
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_w_en      = w_en_q;
  assign o_w_addr    = w_addr_q;
  assign o_w_data    = w_data_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_overflow  = overflow_q;
  assign o_n_words   = n_words_q;

endmodule
`default_nettype wire
